core_pipe_exec_lsq: RTL and testbench

//  Pipelined load/store unit for the execute stage. Replaces the single-access LSU:
//  it keeps up to DEPTH data-memory accesses in flight, and returns results in order

---
 rtl/core_pipe_exec_lsq.sv | 179 +++++++++++++++++
 tb/tb_core_pipe_exec_lsq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_exec_lsq.sv
// Pipelined load/store unit: keeps up to DEPTH dmem accesses in flight and returns
// aligned, extended load results and trap flags strictly in issue order.
module core_pipe_exec_lsq #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wen,
  output logic [4:0]        rsp_rd,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_trap_bus,
  output logic              rsp_trap_addr,
  output logic              dmem_req,
  output logic [XLEN-1:0]   dmem_addr,
  output logic              dmem_wen,
  output logic [XLEN/8-1:0] dmem_strb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_recv,
  input  logic              dmem_err,
  input  logic [XLEN-1:0]   dmem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(XLEN);

  typedef struct packed {
    logic [4:0]      rd;
    logic [1:0]      size;
    logic            sext;
    logic [OB-1:0]   off;
    logic            store;
    logic            done;
    logic            err;
    logic            misal;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        hd;
  logic [PW-1:0] alloc_q, head_q, mem_ptr, scan_idx;
  logic [PW:0]   count_q, count_d, drain_q, drain_d, pend;
  logic          found, full, can_issue, req_misal, accept, retire;
  logic          issued, recv_fill, recv_owed;
  logic [NB-1:0] size_mask;
  logic [OB-1:0] req_off;

  // Request side: valid/ready handshake, request held stable until accepted.
  always_comb begin
    req_off   = req_addr[OB-1:0];
    size_mask = '1;
    req_misal = 1'b0;
    case (req_size)
      2'd0: size_mask = NB'(8'h01);
      2'd1: begin size_mask = NB'(8'h03); req_misal = req_addr[0];      end
      2'd2: begin size_mask = NB'(8'h0F); req_misal = |req_addr[1:0];   end
      default: begin size_mask = '1;      req_misal = |req_addr[2:0];   end
    endcase
    full       = (count_q == (PW+1)'(DEPTH));
    can_issue  = !full && (drain_q == '0);
    dmem_req   = g_resetn && req_valid && !req_misal && can_issue;
    req_ready  = g_resetn && can_issue && (req_misal || dmem_gnt);
    accept     = req_valid && req_ready && !flush;
    issued     = dmem_req && dmem_gnt;
    dmem_addr  = {req_addr[XLEN-1:OB], {OB{1'b0}}};
    dmem_wen   = req_store;
    dmem_strb  = size_mask << req_off;
    dmem_wdata = req_wdata << {req_off, 3'b000};
  end

  // The mem pointer is the oldest live entry not yet done; misaligned entries are
  // allocated done, so they are skipped naturally.
  always_comb begin
    mem_ptr  = head_q;
    scan_idx = head_q;
    found    = 1'b0;
    pend     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && !ent_q[scan_idx].done) begin
        if (!found) mem_ptr = scan_idx;
        found = 1'b1;
        pend  = pend + (PW+1)'(1);
      end
    end
  end

  assign hd        = ent_q[head_q];
  assign rsp_valid = g_resetn && (count_q != '0) && hd.done;
  assign retire    = rsp_valid && rsp_ready;
  assign recv_owed = dmem_recv && ((drain_q != '0) || (pend != '0));
  assign recv_fill = dmem_recv && (drain_q == '0) && (pend != '0);

  always_comb begin
    count_d = count_q + (PW+1)'(accept) - (PW+1)'(retire);
    drain_d = drain_q;
    if (flush) begin
      // Everything memory still owes, including a grant in this very cycle.
      count_d = '0;
      drain_d = drain_q + pend + (PW+1)'(issued) - (PW+1)'(recv_owed);
    end else if (dmem_recv && (drain_q != '0)) begin
      drain_d = drain_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      count_q <= '0;
      drain_q <= '0;
      alloc_q <= '0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      drain_q <= drain_d;
      if (flush) begin
        alloc_q <= '0;
        head_q  <= '0;
      end else begin
        if (accept) alloc_q <= alloc_q + PW'(1);
        if (retire) head_q  <= head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (accept) begin
      ent_q[alloc_q] <= '{rd: req_rd, size: req_size, sext: req_sext, off: req_off,
                          store: req_store, done: req_misal, err: 1'b0,
                          misal: req_misal, data: '0};
    end
    if (g_resetn && recv_fill) begin
      ent_q[mem_ptr].done <= 1'b1;
      ent_q[mem_ptr].err  <= dmem_err;
      ent_q[mem_ptr].data <= dmem_rdata;
    end
  end

  // Response side: shift the addressed lanes down, then mask and extend.
  logic [XLEN-1:0] rd_shift, lo_mask;
  logic [LW-1:0]   msb_idx;
  logic            sign;

  always_comb begin
    rd_shift = hd.data >> {hd.off, 3'b000};
    lo_mask  = '1;
    msb_idx  = LW'(XLEN - 1);
    case (hd.size)
      2'd0: begin lo_mask = XLEN'(8'hFF);         msb_idx = LW'(7);  end
      2'd1: begin lo_mask = XLEN'(16'hFFFF);      msb_idx = LW'(15); end
      2'd2: begin lo_mask = XLEN'(32'hFFFF_FFFF); msb_idx = LW'(31); end
      default: begin lo_mask = '1;                msb_idx = LW'(XLEN - 1); end
    endcase
    sign      = hd.sext && rd_shift[msb_idx];
    rsp_rdata = hd.store ? '0 : ((rd_shift & lo_mask) | ({XLEN{sign}} & ~lo_mask));
  end

  assign rsp_rd        = hd.rd;
  assign rsp_wen       = !hd.store && !hd.err && !hd.misal;
  assign rsp_trap_bus  = hd.err;
  assign rsp_trap_addr = hd.misal;

  // A response with nothing owed is a memory protocol error; it is ignored.
  assert property (@(posedge g_clk) disable iff (!g_resetn)
                   dmem_recv |-> ((drain_q != '0) || (pend != '0)));

endmodule

// File: tb/tb_core_pipe_exec_lsq.sv
// Bench for core_pipe_exec_lsq: directed vectors, a queue-level reference model
// compared every cycle, plus literal expectations from hand-worked cases.
module tb_core_pipe_exec_lsq;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic        g_clk, g_resetn, flush;
  logic        req_valid, req_ready, req_store, req_sext;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_ready, rsp_wen, rsp_trap_bus, rsp_trap_addr;
  logic [4:0]  rsp_rd;
  logic [63:0] rsp_rdata;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;

  int checks   = 0;
  int failures = 0;

  core_pipe_exec_lsq #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_store(req_store), .req_size(req_size),
    .req_sext(req_sext), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wen(rsp_wen),
    .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .rsp_trap_bus(rsp_trap_bus),
    .rsp_trap_addr(rsp_trap_addr),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
  );

  // Clock and reset block
  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue of accesses plus responses still owed after a flush
  typedef struct {
    logic [4:0]  rd;
    logic        store;
    logic [1:0]  size;
    logic        sext;
    logic [2:0]  off;
    logic        done;
    logic        err;
    logic        misal;
    logic [63:0] data;
  } ment_t;

  ment_t mq[$];
  int    m_drain = 0;

  function automatic bit m_misal();
    return (req_addr & ((64'(1) << req_size) - 64'(1))) != 64'(0);
  endfunction

  function automatic bit m_full();
    return mq.size() == DEPTH;
  endfunction

  function automatic bit e_req_ready();
    return g_resetn && !m_full() && (m_drain == 0) && (m_misal() || dmem_gnt);
  endfunction

  function automatic bit e_dmem_req();
    return g_resetn && req_valid && !m_misal() && !m_full() && (m_drain == 0);
  endfunction

  function automatic bit e_rsp_valid();
    return g_resetn && (mq.size() > 0) && mq[0].done;
  endfunction

  function automatic logic [7:0] e_strb();
    logic [15:0] s;
    s = ((16'(1) << (1 << req_size)) - 16'(1)) << req_addr[2:0];
    return s[7:0];
  endfunction

  function automatic logic [63:0] e_rdata(input ment_t e);
    logic [63:0] v, m;
    int nbits;
    if (e.store) return 64'(0);
    nbits = 8 << e.size;
    v = e.data >> (8 * int'(e.off));
    if (nbits < 64) begin
      m = (64'(1) << nbits) - 64'(1);
      v = v & m;
      if (e.sext && v[nbits-1]) v = v | ~m;
    end
    return v;
  endfunction

  always @(posedge g_clk) begin : model
    bit    acc, ret, iss;
    int    owed;
    ment_t ne;
    if (!g_resetn) begin
      mq.delete();
      m_drain = 0;
    end else begin
      acc  = req_valid && e_req_ready() && !flush;
      ret  = e_rsp_valid() && rsp_ready;
      iss  = e_dmem_req() && dmem_gnt;
      owed = 0;
      foreach (mq[i]) if (!mq[i].done) owed++;
      if (flush) begin
        m_drain = m_drain + owed + int'(iss) - ((dmem_recv && (m_drain > 0 || owed > 0)) ? 1 : 0);
        mq.delete();
      end else begin
        if (dmem_recv) begin
          if (m_drain > 0) m_drain--;
          else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].done) begin
                ne = mq[i];
                ne.done = 1'b1;
                ne.err  = dmem_err;
                ne.data = dmem_rdata;
                mq[i] = ne;
                break;
              end
            end
          end
        end
        if (ret) void'(mq.pop_front());
        if (acc) begin
          ne.rd = req_rd; ne.store = req_store; ne.size = req_size; ne.sext = req_sext;
          ne.off = req_addr[2:0]; ne.misal = m_misal(); ne.done = m_misal();
          ne.err = 1'b0; ne.data = 64'(0);
          mq.push_back(ne);
        end
      end
    end
  end

  // Compare process: every cycle, on the falling edge
  always @(negedge g_clk) begin
    chk("m_rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid()));
    chk("m_req_ready", 64'(req_ready), 64'(e_req_ready()));
    chk("m_dmem_req", 64'(dmem_req), 64'(e_dmem_req()));
    if (e_dmem_req()) begin
      chk("m_dmem_addr", dmem_addr, req_addr & ~64'h7);
      chk("m_dmem_strb", 64'(dmem_strb), 64'(e_strb()));
      chk("m_dmem_wdata", dmem_wdata, req_wdata << (8 * int'(req_addr[2:0])));
      chk("m_dmem_wen", 64'(dmem_wen), 64'(req_store));
    end
    if (e_rsp_valid()) begin
      chk("m_rsp_rd", 64'(rsp_rd), 64'(mq[0].rd));
      chk("m_rsp_wen", 64'(rsp_wen), 64'(!mq[0].store && !mq[0].err && !mq[0].misal));
      chk("m_rsp_rdata", rsp_rdata, e_rdata(mq[0]));
      chk("m_trap_bus", 64'(rsp_trap_bus), 64'(mq[0].err));
      chk("m_trap_addr", 64'(rsp_trap_addr), 64'(mq[0].misal));
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    flush = 0; req_valid = 0; req_addr = 0; req_wdata = 0; req_store = 0;
    req_size = 0; req_sext = 0; req_rd = 0; rsp_ready = 0;
    dmem_gnt = 0; dmem_recv = 0; dmem_err = 0; dmem_rdata = 0;
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
    idle_inputs();
  endtask

  task automatic neg();
    @(negedge g_clk);
  endtask

  task automatic drive_load(input logic [63:0] a, input logic [1:0] sz, input logic sx,
                            input logic [4:0] rd);
    req_valid = 1; req_store = 0; req_addr = a; req_size = sz; req_sext = sx; req_rd = rd;
  endtask

  task automatic drive_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    req_valid = 1; req_store = 1; req_addr = a; req_size = sz; req_wdata = wd; req_rd = 0;
  endtask

  task automatic drive_recv(input logic [63:0] d, input logic e);
    dmem_recv = 1; dmem_rdata = d; dmem_err = e;
  endtask

  initial begin
    g_resetn = 0;
    idle_inputs();
    drive_load(64'h1000, 2, 0, 1); dmem_gnt = 1;
    neg();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_dmem_req", 64'(dmem_req), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge g_clk); #1;
    neg();
    chk("rst2_dmem_req", 64'(dmem_req), 64'(0));
    cyc(); g_resetn = 1;
    neg(); chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));

    // Signed word load from the upper half of a doubleword
    cyc(); rsp_ready = 1; drive_load(64'h1004, 2, 1, 5); dmem_gnt = 1;
    neg(); chk("a_addr", dmem_addr, 64'h1000); chk("a_ready", 64'(req_ready), 64'(1));
    cyc(); rsp_ready = 1; drive_recv(64'h8000_0001_1234_5678, 0);
    neg(); chk("a_valid_early", 64'(rsp_valid), 64'(0));
    cyc(); rsp_ready = 1;
    neg(); chk("a_valid", 64'(rsp_valid), 64'(1));
    chk("a_rdata", rsp_rdata, 64'hFFFF_FFFF_8000_0001);
    chk("a_wen", 64'(rsp_wen), 64'(1)); chk("a_rd", 64'(rsp_rd), 64'(5));
    cyc(); neg(); chk("a_retired", 64'(rsp_valid), 64'(0));

    // Halfword store into the top lanes
    cyc(); rsp_ready = 1; drive_store(64'h2006, 1, 64'hABCD); dmem_gnt = 1;
    neg(); chk("b_strb", 64'(dmem_strb), 64'hC0);
    chk("b_wdata", dmem_wdata, 64'hABCD_0000_0000_0000);
    chk("b_addr", dmem_addr, 64'h2000); chk("b_wen", 64'(dmem_wen), 64'(1));
    cyc(); rsp_ready = 1; drive_recv(64'h0, 0);
    neg();
    cyc(); rsp_ready = 1;
    neg(); chk("b_valid", 64'(rsp_valid), 64'(1)); chk("b_rsp_wen", 64'(rsp_wen), 64'(0));
    chk("b_rdata", rsp_rdata, 64'h0);

    // Three back-to-back loads with responses held off
    cyc(); rsp_ready = 1; drive_load(64'h3000, 3, 0, 1); dmem_gnt = 1; neg();
    cyc(); rsp_ready = 1; drive_load(64'h3008, 3, 0, 2); dmem_gnt = 1; neg();
    cyc(); rsp_ready = 1; drive_load(64'h3010, 3, 0, 3); dmem_gnt = 1;
    neg(); chk("c_stall", 64'(req_ready), 64'(0)); chk("c_no_req", 64'(dmem_req), 64'(0));
    cyc(); rsp_ready = 1; drive_load(64'h3010, 3, 0, 3); dmem_gnt = 1; drive_recv(64'h1111, 0);
    neg(); chk("c_stall2", 64'(req_ready), 64'(0));
    cyc(); rsp_ready = 1; drive_load(64'h3010, 3, 0, 3); dmem_gnt = 1; drive_recv(64'h2222, 0);
    neg(); chk("c_full_retire", 64'(req_ready), 64'(0)); chk("c_rd1", 64'(rsp_rd), 64'(1));
    chk("c_rdata1", rsp_rdata, 64'h1111);
    cyc(); rsp_ready = 1; drive_load(64'h3010, 3, 0, 3); dmem_gnt = 1;
    neg(); chk("c_accept3", 64'(req_ready), 64'(1)); chk("c_rd2", 64'(rsp_rd), 64'(2));
    cyc(); rsp_ready = 1; drive_recv(64'h3333, 0); neg();
    cyc(); rsp_ready = 1;
    neg(); chk("c_rd3", 64'(rsp_rd), 64'(3)); chk("c_rdata3", rsp_rdata, 64'h3333);

    // Misaligned load between two aligned loads
    cyc(); rsp_ready = 1; drive_load(64'h4000, 2, 0, 6); dmem_gnt = 1; neg();
    cyc(); rsp_ready = 1; drive_load(64'h1002, 2, 0, 7); drive_recv(64'h0000_0000_CAFE_F00D, 0);
    neg(); chk("d_no_req", 64'(dmem_req), 64'(0)); chk("d_misal_ready", 64'(req_ready), 64'(1));
    cyc(); rsp_ready = 1; drive_load(64'h4008, 2, 0, 8); dmem_gnt = 1;
    neg(); chk("d_rd6", 64'(rsp_rd), 64'(6)); chk("d_rdata6", rsp_rdata, 64'hCAFE_F00D);
    cyc(); rsp_ready = 1; drive_load(64'h4008, 2, 0, 8); dmem_gnt = 1;
    neg(); chk("d_rd7", 64'(rsp_rd), 64'(7)); chk("d_trap_addr", 64'(rsp_trap_addr), 64'(1));
    chk("d_wen7", 64'(rsp_wen), 64'(0));
    cyc(); rsp_ready = 1; drive_recv(64'h9999_9999_1234_5678, 0); neg();
    cyc(); rsp_ready = 1;
    neg(); chk("d_rd8", 64'(rsp_rd), 64'(8)); chk("d_rdata8", rsp_rdata, 64'h1234_5678);

    // Bus error on a load
    cyc(); drive_load(64'h5000, 3, 0, 9); dmem_gnt = 1; neg();
    cyc(); drive_recv(64'h55, 1); neg();
    cyc(); rsp_ready = 1;
    neg(); chk("e_trap_bus", 64'(rsp_trap_bus), 64'(1)); chk("e_wen", 64'(rsp_wen), 64'(0));

    // Flush with two accesses in flight
    cyc(); drive_load(64'h6000, 3, 0, 10); dmem_gnt = 1; neg();
    cyc(); drive_load(64'h6008, 3, 0, 11); dmem_gnt = 1; neg();
    cyc(); flush = 1; neg();
    cyc(); drive_recv(64'h1, 0); drive_load(64'h7000, 3, 0, 12); dmem_gnt = 1;
    neg(); chk("f_drain_ready", 64'(req_ready), 64'(0)); chk("f_drain_req", 64'(dmem_req), 64'(0));
    chk("f_dropped", 64'(rsp_valid), 64'(0));
    cyc(); drive_recv(64'h2, 0); drive_load(64'h7000, 3, 0, 12); dmem_gnt = 1;
    neg(); chk("f_drain_ready2", 64'(req_ready), 64'(0)); chk("f_dropped2", 64'(rsp_valid), 64'(0));
    cyc(); drive_load(64'h7000, 3, 0, 12); dmem_gnt = 1;
    neg(); chk("f_ready_again", 64'(req_ready), 64'(1));
    cyc(); drive_recv(64'hC0DE, 0); neg();
    cyc(); rsp_ready = 1;
    neg(); chk("f_rd12", 64'(rsp_rd), 64'(12)); chk("f_rdata12", rsp_rdata, 64'hC0DE);

    // Reset with two accesses in flight
    cyc(); drive_load(64'h8000, 3, 0, 13); dmem_gnt = 1; neg();
    cyc(); drive_load(64'h8008, 3, 0, 14); dmem_gnt = 1; neg();
    cyc(); g_resetn = 0; drive_load(64'h9000, 3, 0, 15); dmem_gnt = 1;
    neg(); chk("g_rst_valid", 64'(rsp_valid), 64'(0)); chk("g_rst_req", 64'(dmem_req), 64'(0));
    chk("g_rst_ready", 64'(req_ready), 64'(0));
    cyc(); g_resetn = 1;
    neg(); chk("g_post_valid", 64'(rsp_valid), 64'(0)); chk("g_post_req", 64'(dmem_req), 64'(0));
    cyc(); drive_load(64'hA000, 3, 0, 15); dmem_gnt = 1;
    neg(); chk("g_accept1", 64'(req_ready), 64'(1));
    cyc(); drive_load(64'hA008, 3, 0, 16); dmem_gnt = 1;
    neg(); chk("g_accept2", 64'(req_ready), 64'(1));
    cyc(); drive_recv(64'hF0, 0); neg();
    cyc(); rsp_ready = 1; drive_recv(64'h0F, 0);
    neg(); chk("g_rd15", 64'(rsp_rd), 64'(15));
    cyc(); rsp_ready = 1;
    neg(); chk("g_rd16", 64'(rsp_rd), 64'(16));
    cyc(); neg(); chk("g_empty", 64'(rsp_valid), 64'(0));
    cyc(); neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
